// File: rtl/l1_dm_cache.sv
// l1_dm_cache: direct-mapped, write-through, no-write-allocate L1 with a 16-byte line.
// Latency: a read hit returns one cycle after sampling and completes in two cycles; a miss refills four beats, then looks the address up again.
// Backpressure: the core holds its request until the ready pulse; mem_req_* stay stable until mem_req_ready is seen.
// Ports: clk/rst (synchronous, active-high); core_req/core_resp (core side, packed structs);
//        mem_req_valid/we/addr/wdata/wstrb with mem_req_ready (backing-memory request);
//        mem_resp_valid/mem_resp_rdata (read beat or write acknowledge).

package l1_dm_cache_pkg;
   typedef struct packed {
      logic        valid;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } mem_req_t;

   typedef struct packed {
      logic        ready;
      logic [31:0] rdata;
   } mem_resp_t;
endpackage

module l1_dm_cache
   import l1_dm_cache_pkg::*;
#(
   parameter int LINES          = 16,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  mem_req_t    core_req,
   output mem_resp_t   core_resp,
   output logic        mem_req_valid,
   output logic        mem_req_we,
   output logic [31:0] mem_req_addr,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_wstrb,
   input  logic        mem_req_ready,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_rdata
);

   localparam int IDX_W  = $clog2(LINES);
   localparam int WORD_W = $clog2(WORDS_PER_LINE);
   localparam int TAG_W  = 32 - 4 - IDX_W;

   typedef enum logic [2:0] {IDLE, RESP, REFILL_REQ, REFILL_DATA, WR_REQ, WR_ACK} state_t;

   state_t state_q, state_d;

   logic [LINES-1:0]  valid_q;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [31:0]       data_q [LINES][WORDS_PER_LINE];
   logic [WORD_W-1:0] beat_q;
   logic [31:0]       lat_addr;
   logic [31:0]       lat_wdata;
   logic [3:0]        lat_wstrb;
   logic [31:0]       rdata_q;

   // Lookup fields of the live request and of the latched (refill/write) address.
   logic [IDX_W-1:0]  req_idx, lat_idx;
   logic [TAG_W-1:0]  req_tag, lat_tag;
   logic [WORD_W-1:0] req_word;
   logic              hit;
   logic              unused_addr_lsb;

   assign req_idx         = core_req.addr[4 +: IDX_W];
   assign req_tag         = core_req.addr[31 -: TAG_W];
   assign req_word        = core_req.addr[2 +: WORD_W];
   assign lat_idx         = lat_addr[4 +: IDX_W];
   assign lat_tag         = lat_addr[31 -: TAG_W];
   assign hit             = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign unused_addr_lsb = ^core_req.addr[1:0];

   logic last_beat;
   assign last_beat = (state_q == REFILL_DATA) && mem_resp_valid && (beat_q == '1);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d         = state_q;
      core_resp.ready = 1'b0;
      core_resp.rdata = rdata_q;
      mem_req_valid   = 1'b0;
      mem_req_we      = 1'b0;
      mem_req_addr    = 32'h0;
      mem_req_wdata   = 32'h0;
      mem_req_wstrb   = 4'h0;
      case (state_q)
         IDLE: begin
            if (core_req.valid) begin
               if (core_req.we) state_d = WR_REQ;
               else if (hit)    state_d = RESP;
               else             state_d = REFILL_REQ;
            end
         end
         RESP: begin
            core_resp.ready = 1'b1;
            state_d         = IDLE;
         end
         REFILL_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = lat_addr;
            if (mem_req_ready) state_d = REFILL_DATA;
         end
         REFILL_DATA: begin
            // Refill ends silently; the re-lookup in IDLE produces the response.
            if (last_beat) state_d = IDLE;
         end
         WR_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_we    = 1'b1;
            mem_req_addr  = lat_addr;
            mem_req_wdata = lat_wdata;
            mem_req_wstrb = lat_wstrb;
            if (mem_req_ready) state_d = WR_ACK;
         end
         WR_ACK: begin
            if (mem_resp_valid) state_d = RESP;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state: valid bits, beat counter, latched request, response data.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= '0;
         beat_q    <= '0;
         lat_addr  <= 32'h0;
         lat_wdata <= 32'h0;
         lat_wstrb <= 4'h0;
         rdata_q   <= 32'h0;
      end else begin
         case (state_q)
            IDLE: begin
               if (core_req.valid) begin
                  if (core_req.we) begin
                     lat_addr  <= {core_req.addr[31:2], 2'b00};
                     lat_wdata <= core_req.wdata;
                     lat_wstrb <= core_req.wstrb;
                  end else if (hit) begin
                     rdata_q <= data_q[req_idx][req_word];
                  end else begin
                     // The victim is invalidated up front so a line left
                     // half-written by an abandoned refill can never hit.
                     lat_addr         <= {core_req.addr[31:4], 4'h0};
                     valid_q[req_idx] <= 1'b0;
                     beat_q           <= '0;
                  end
               end
            end
            REFILL_DATA: begin
               if (mem_resp_valid) beat_q <= beat_q + 1'b1;
               if (last_beat)      valid_q[lat_idx] <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Tag and data arrays carry no reset; the valid bits qualify them.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == IDLE && core_req.valid && core_req.we && hit) begin
            for (int b = 0; b < 4; b++) begin
               if (core_req.wstrb[b]) data_q[req_idx][req_word][8*b +: 8] <= core_req.wdata[8*b +: 8];
            end
         end
         if (state_q == REFILL_DATA && mem_resp_valid) data_q[lat_idx][beat_q] <= mem_resp_rdata;
         if (last_beat) tag_q[lat_idx] <= lat_tag;
      end
   end

endmodule

// File: doc/l1_dm_cache.md
L1_DM_CACHE -- requirements
Module: l1_dm_cache

Interface
REQ-001 Parameter LINES, default 16, number of cache lines; power of two, 2..256.
REQ-002 Parameter WORDS_PER_LINE, fixed 4; 32-bit words, 16-byte line.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 core_req  in  mem_req_t  request from the IF/data arbiter. Fields: valid, we, addr[31:0], wdata[31:0], wstrb[3:0].
REQ-006 core_resp  out  mem_resp_t  response to the arbiter. Fields: ready (one-cycle completion pulse), rdata[31:0].
REQ-007 mem_req_valid  out  1  backing-memory request valid.
REQ-008 mem_req_we  out  1  1 = word write, 0 = line read.
REQ-009 mem_req_addr  out  32  line-aligned address for reads; word address for writes.
REQ-010 mem_req_wdata  out  32 and mem_req_wstrb  out  4: write data and byte enables.
REQ-011 mem_req_ready  in  1  memory accepts the request when valid and ready are both high.
REQ-012 mem_resp_valid  in  1 and mem_resp_rdata  in  32: read beat, or write acknowledge (data ignored).

Function
REQ-013 Address split: [3:2] word within line, [3+log2(LINES):4] index, remaining upper bits tag; addr[1:0] ignored.
REQ-014 Direct-mapped organisation. Per-line state: valid bit, tag, 4 data words. Write-through, no-write-allocate.
REQ-015 Requester holds core_req stable, with valid high, until it sees core_resp.ready. core_resp.ready SHALL be high for exactly one cycle per completed request.
REQ-016 FSM states: IDLE, RESP, REFILL_REQ, REFILL_DATA, WR_REQ, WR_ACK.
REQ-017 IDLE, valid && !we && hit: rdata is registered from the array; go to RESP. Read-hit latency is one cycle from the sampling edge.
REQ-018 IDLE, valid && !we && miss: latch the line address; go to REFILL_REQ.
REQ-019 IDLE, valid && we: latch addr/wdata/wstrb. On a hit, merge wdata into the cached word per wstrb in the same edge. Go to WR_REQ.
REQ-020 RESP: ready=1 for one cycle, then IDLE. Back-to-back hits therefore complete every 2 cycles.
REQ-021 REFILL_REQ: mem_req_valid=1, we=0, addr={tag,index,4'b0}. Hold until mem_req_ready, then go to REFILL_DATA.
REQ-022 REFILL_DATA: a 2-bit beat counter writes words 0..3 in order on each mem_resp_valid. On the 4th beat, write the tag, set valid, and go to IDLE. A hit is then re-looked-up; no ready pulse is issued from a refill state.
REQ-023 WR_REQ: mem_req_valid=1, we=1, with latched addr/wdata/wstrb. Hold until mem_req_ready, then go to WR_ACK.
REQ-024 WR_ACK: on mem_resp_valid, go to RESP; the ready pulse follows.
REQ-025 All mem_req_* outputs SHALL be stable while mem_req_valid is high and ready is low.
REQ-026 If core_req changes during a refill (arbiter switches requester), the refill still completes. IDLE then services whatever request is present.
REQ-027 If core_req changes or drops during a write, the memory write still completes and RESP is issued. The arbiter routes the pulse; a re-issued write is tolerated (idempotent).
REQ-028 mem_resp_valid in IDLE, RESP, REFILL_REQ or WR_REQ SHALL be ignored.
REQ-029 A write miss SHALL NOT modify any line state.

Reset
REQ-030 rst SHALL force state IDLE, clear all valid bits and the beat counter, and drive core_resp and all mem_req_* outputs to 0.
REQ-031 Tag and data arrays need no reset.
REQ-032 rst mid-refill or mid-write abandons the operation; the partially filled line stays invalid.
REQ-033 The first request is sampled in the cycle after rst deasserts.

Verification
REQ-034 Cold read 0x0000_0104 -> one mem read at 0x0000_0100; beats A,B,C,D -> ready pulse with rdata=B. Re-read 0x104 -> rdata=B with ready one cycle after sampling, and no mem request.
REQ-035 Write hit 0x104, wdata 0x1122_3344, wstrb 4'b0011 -> mem write to 0x104 with wstrb 0011; ack -> ready pulse. Next read 0x104 -> {B[31:16],16'h3344}.
REQ-036 Write miss 0x0000_0800 -> mem write only. Read 0x800 then misses and refills.
REQ-037 Conflict: read 0x100 then 0x500 (LINES=16, same index) -> two refills. Read 0x100 again -> third refill.
REQ-038 Hold mem_req_ready=0 for 5 cycles during REFILL_REQ -> outputs stable throughout. Switch core_req.addr mid-refill -> refill completes, then the new address is serviced.
REQ-039 Assert rst after the 2nd refill beat -> all outputs 0 next cycle. Read of the same address refills again.
